// File: rtl/iic_access_arbiter.sv
// Round-robin arbiter serialising two requesters' byte read/write calls onto one IIC EEPROM engine.
// Grant 1 cycle after request; requests wait while BUSY, in the post-read GAP and for TWR cycles after writes.
module iic_access_arbiter #(
    parameter int TWR = 250000,
    parameter int CW  = 18
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [1:0] iCall0,
    input  logic [7:0] iAddr0,
    input  logic [7:0] iData0,
    output logic       oDone0,
    output logic [7:0] oData0,
    input  logic [1:0] iCall1,
    input  logic [7:0] iAddr1,
    input  logic [7:0] iData1,
    output logic       oDone1,
    output logic [7:0] oData1,
    output logic [1:0] oIICCall,
    output logic [7:0] oIICAddr,
    output logic [7:0] oIICData,
    input  logic       iIICDone,
    input  logic [7:0] iIICData
);

    typedef enum logic [1:0] {IDLE, BUSY, GAP, TWAIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          owner, wr, last;
    logic          pend0, pend1;
    logic          grant, win;
    logic [1:0]    win_call;
    logic          finish;

    assign pend0    = |iCall0;
    assign pend1    = |iCall1;
    assign win_call = win ? iCall1 : iCall0;
    assign finish   = (state == BUSY) && iIICDone;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        win       = 1'b0;
        case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    grant     = 1'b1;
                    // On a tie the requester that was not served last goes first.
                    win       = (pend0 && pend1) ? ~last : pend1;
                    state_nxt = BUSY;
                end
            end
            BUSY:    if (iIICDone) state_nxt = wr ? TWAIT : GAP;
            GAP:     state_nxt = IDLE;
            TWAIT:   if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            oIICCall <= 2'b00;
            oIICAddr <= 8'h00;
            oIICData <= 8'h00;
            oDone0   <= 1'b0;
            oDone1   <= 1'b0;
            oData0   <= 8'h00;
            oData1   <= 8'h00;
            owner    <= 1'b0;
            wr       <= 1'b0;
            last     <= 1'b1;
            cnt      <= '0;
        end else begin
            oDone0 <= 1'b0;
            oDone1 <= 1'b0;
            if (grant) begin
                oIICAddr <= win ? iAddr1 : iAddr0;
                oIICData <= win ? iData1 : iData0;
                oIICCall <= win_call[1] ? 2'b10 : 2'b01;
                owner    <= win;
                wr       <= win_call[1];
                last     <= win;
            end
            // The engine sees its call high during the done cycle so its own sequencer can idle.
            if (finish) begin
                oIICCall <= 2'b00;
                if (owner) oDone1 <= 1'b1;
                else       oDone0 <= 1'b1;
                if (!wr) begin
                    if (owner) oData1 <= iIICData;
                    else       oData0 <= iIICData;
                end else begin
                    cnt <= CW'(TWR - 1);
                end
            end
            if (state == TWAIT && cnt != '0) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_iic_access_arbiter.sv
// Bench for iic_access_arbiter: directed table plus randomized calls checked against a spec-level model.
module tb_iic_access_arbiter;

    localparam int TWR = 8;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic [1:0] iCall0 = '0, iCall1 = '0;
    logic [7:0] iAddr0 = '0, iAddr1 = '0, iData0 = '0, iData1 = '0;
    logic       oDone0, oDone1;
    logic [7:0] oData0, oData1;
    logic [1:0] oIICCall;
    logic [7:0] oIICAddr, oIICData;
    logic       iIICDone = 1'b0;
    logic [7:0] iIICData = '0;

    iic_access_arbiter #(.TWR(TWR), .CW(4)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .iCall0(iCall0), .iAddr0(iAddr0), .iData0(iData0), .oDone0(oDone0), .oData0(oData0),
        .iCall1(iCall1), .iAddr1(iAddr1), .iData1(iData1), .oDone1(oDone1), .oData1(oData1),
        .oIICCall(oIICCall), .oIICAddr(oIICAddr), .oIICData(oIICData),
        .iIICDone(iIICDone), .iIICData(iIICData)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [1:0] c0;
        logic [7:0] a0, d0;
        logic [1:0] c1;
        logic [7:0] a1, d1;
        int         lat;
        logic [7:0] rd;
        int         mode;      // bit0: drop calls with done, bit1: disturb addr/data mid-op
        int         exp_wait;
        logic [1:0] exp_call;
        logic [7:0] exp_addr, exp_data;
        bit         exp_win;
    } vec_t;

    int vec  = 0;
    int errs = 0;

    // Reference model state
    bit         m_last    = 1'b1;
    bit         m_prev_wr = 1'b0;
    bit         m_first   = 1'b1;
    logic [7:0] m_data [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLOCK) begin
        if (RESET && (oIICCall == 2'b11 || (oDone0 && oDone1))) begin
            vec++;
            errs++;
            $display("FAIL exclusivity call=%b done0=%b done1=%b required no overlap", oIICCall, oDone0, oDone1);
        end
    end

    function automatic vec_t mk(input logic [1:0] c0, input logic [7:0] a0, input logic [7:0] d0,
                                input logic [1:0] c1, input logic [7:0] a1, input logic [7:0] d1,
                                input int lat, input logic [7:0] rd, input int mode, input int ew,
                                input logic [1:0] ec, input logic [7:0] ea, input logic [7:0] ed,
                                input bit ewin);
        vec_t v;
        v.c0 = c0; v.a0 = a0; v.d0 = d0; v.c1 = c1; v.a1 = a1; v.d1 = d1;
        v.lat = lat; v.rd = rd; v.mode = mode; v.exp_wait = ew;
        v.exp_call = ec; v.exp_addr = ea; v.exp_data = ed; v.exp_win = ewin;
        return v;
    endfunction

    // Spec rules: pending = call!=0; tie goes to the one not served last; write bit wins.
    function automatic vec_t model_fill(input vec_t v);
        bit         p0, p1, w;
        logic [1:0] wc;
        p0 = (v.c0 != 2'b00);
        p1 = (v.c1 != 2'b00);
        w  = (p0 && p1) ? !m_last : p1;
        wc = w ? v.c1 : v.c0;
        v.exp_win  = w;
        v.exp_call = wc[1] ? 2'b10 : 2'b01;
        v.exp_addr = w ? v.a1 : v.a0;
        v.exp_data = w ? v.d1 : v.d0;
        v.exp_wait = m_first ? 1 : (m_prev_wr ? TWR + 1 : 2);
        return v;
    endfunction

    // Called at a falling edge; returns at the falling edge where the done pulse is visible.
    task automatic run_op(input vec_t v);
        int n;
        bit is_wr;
        iCall0 = v.c0; iAddr0 = v.a0; iData0 = v.d0;
        iCall1 = v.c1; iAddr1 = v.a1; iData1 = v.d1;
        n = 0;
        do begin
            @(negedge CLOCK);
            n++;
            if (n == 1) chk("done_single_cycle", {30'd0, oDone0, oDone1}, 32'd0);
        end while (oIICCall == 2'b00 && n < 60);
        chk("call_wait", n, v.exp_wait);
        if (oIICCall == 2'b00) return;
        chk("call", oIICCall, v.exp_call);
        chk("addr", oIICAddr, v.exp_addr);
        chk("wdata", oIICData, v.exp_data);
        for (int j = 1; j < v.lat; j++) begin
            @(negedge CLOCK);
            if (j == 1 && (v.mode & 2) != 0) begin
                iAddr0 = ~iAddr0; iAddr1 = ~iAddr1; iData0 = ~iData0; iData1 = ~iData1;
                iCall0 = 2'b01;
            end
        end
        chk("call_hold", oIICCall, v.exp_call);
        chk("addr_hold", oIICAddr, v.exp_addr);
        chk("wdata_hold", oIICData, v.exp_data);
        iIICDone = 1'b1;
        iIICData = v.rd;
        if ((v.mode & 1) != 0) begin
            iCall0 = 2'b00;
            iCall1 = 2'b00;
        end
        @(negedge CLOCK);
        iIICDone = 1'b0;
        iIICData = 8'($urandom);
        is_wr = (v.exp_call == 2'b10);
        if (!is_wr) m_data[v.exp_win] = v.rd;
        chk("call_clear", oIICCall, 2'b00);
        chk("done0", oDone0, !v.exp_win);
        chk("done1", oDone1, v.exp_win);
        chk("rdata0", oData0, m_data[0]);
        chk("rdata1", oData1, m_data[1]);
        m_last    = v.exp_win;
        m_prev_wr = is_wr;
        m_first   = 1'b0;
    endtask

    vec_t tbl [9];
    vec_t rv;
    int   n;

    initial begin
        m_data[0] = '0;
        m_data[1] = '0;
        //           c0     a0     d0     c1     a1     d1   lat  rd    md wait call   addr   data  win
        tbl[0] = mk(2'b01, 8'h3C, 8'h00, 2'b00, 8'h00, 8'h00, 40, 8'hA5, 0, 1,     2'b01, 8'h3C, 8'h00, 0);
        tbl[1] = mk(2'b00, 8'h00, 8'h00, 2'b10, 8'h10, 8'h5A, 5,  8'h77, 0, 2,     2'b10, 8'h10, 8'h5A, 1);
        tbl[2] = mk(2'b01, 8'h20, 8'h11, 2'b00, 8'h00, 8'h00, 3,  8'hC3, 0, TWR+1, 2'b01, 8'h20, 8'h11, 0);
        tbl[3] = mk(2'b01, 8'h30, 8'hA0, 2'b01, 8'h31, 8'hB1, 2,  8'h5E, 0, 2,     2'b01, 8'h31, 8'hB1, 1);
        tbl[4] = mk(2'b01, 8'h30, 8'hA0, 2'b01, 8'h31, 8'hB1, 2,  8'h6F, 0, 2,     2'b01, 8'h30, 8'hA0, 0);
        tbl[5] = mk(2'b01, 8'h30, 8'hA0, 2'b01, 8'h31, 8'hB1, 1,  8'h7A, 0, 2,     2'b01, 8'h31, 8'hB1, 1);
        tbl[6] = mk(2'b01, 8'h30, 8'hA0, 2'b01, 8'h31, 8'hB1, 4,  8'h8B, 0, 2,     2'b01, 8'h30, 8'hA0, 0);
        tbl[7] = mk(2'b11, 8'h44, 8'h99, 2'b00, 8'h00, 8'h00, 6,  8'hEE, 2, 2,     2'b10, 8'h44, 8'h99, 0);
        tbl[8] = mk(2'b00, 8'h00, 8'h00, 2'b01, 8'h55, 8'h66, 5,  8'h12, 1, TWR+1, 2'b01, 8'h55, 8'h66, 1);

        repeat (2) @(negedge CLOCK);
        chk("reset_outputs", {oIICCall, oIICAddr, oIICData, oDone0, oDone1, oData0}, 32'd0);
        chk("reset_data1", oData1, 8'h00);
        RESET = 1'b1;

        foreach (tbl[i]) run_op(tbl[i]);

        // Reset in the middle of a read: everything clears asynchronously, tie order restarts.
        iCall0 = 2'b01; iAddr0 = 8'h66; iCall1 = 2'b00;
        n = 0;
        do begin
            @(negedge CLOCK);
            n++;
        end while (oIICCall == 2'b00 && n < 20);
        chk("pre_reset_call", oIICCall, 2'b01);
        @(negedge CLOCK);
        RESET = 1'b0;
        #1;
        chk("midop_reset_outputs", {oIICCall, oIICAddr, oIICData, oDone0, oDone1, oData0}, 32'd0);
        chk("midop_reset_data1", oData1, 8'h00);
        iCall0 = 2'b00;
        @(negedge CLOCK);
        RESET     = 1'b1;
        m_last    = 1'b1;
        m_first   = 1'b1;
        m_prev_wr = 1'b0;
        m_data[0] = '0;
        m_data[1] = '0;
        run_op(mk(2'b01, 8'h70, 8'h01, 2'b01, 8'h71, 8'h02, 3, 8'h3D, 0, 1, 2'b01, 8'h70, 8'h01, 0));

        for (int k = 0; k < 40; k++) begin
            rv.c0 = 2'($urandom_range(0, 3));
            rv.c1 = 2'($urandom_range(0, 3));
            if (rv.c0 == 2'b00 && rv.c1 == 2'b00) rv.c0 = 2'b01;
            rv.a0 = 8'($urandom); rv.d0 = 8'($urandom);
            rv.a1 = 8'($urandom); rv.d1 = 8'($urandom);
            rv.lat  = $urandom_range(1, 6);
            rv.rd   = 8'($urandom);
            rv.mode = $urandom_range(0, 3);
            run_op(model_fill(rv));
        end

        iCall0 = 2'b00;
        iCall1 = 2'b00;
        repeat (TWR + 4) @(negedge CLOCK);
        chk("final_idle_call", oIICCall, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/iic_access_arbiter.md
# iic_access_arbiter

Two-port arbiter and sequencer in front of the single-byte IIC EEPROM save engine (`iic_savemod`). Two independent requesters issue byte-write or random-read calls. The block grants them round-robin and forwards one call at a time to the engine, latching address and data at grant. It returns a one-cycle done pulse and the read data to the winner, and enforces the EEPROM internal write-cycle time (tWR) before the engine is used again.

## Interface
- `TWR`, 250000: post-write idle cycles (5 ms at 50 MHz).
- `CW`, 18: width of the tWR counter; must hold `TWR`.
- `CLOCK` in 1: single clock for the whole block.
- `RESET` in 1: reset, asynchronous, active-low.
- `iCall0` in 2: requester 0 call. Bit 1 is write, bit 0 is read. If both bits are set, write wins.
- `iAddr0` in 8: requester 0 word address.
- `iData0` in 8: requester 0 write data.
- `oDone0` out 1: requester 0 completion pulse.
- `oData0` out 8: requester 0 last read byte.
- `iCall1`, `iAddr1`, `iData1`, `oDone1`, `oData1`: same as requester 0, for requester 1.
- `oIICCall` out 2: call to the engine, at most one bit high.
- `oIICAddr` out 8: latched word address to the engine.
- `oIICData` out 8: latched write data to the engine.
- `iIICDone` in 1: engine one-cycle done pulse.
- `iIICData` in 8: engine read byte, valid while `iIICDone` is high.

## Operation
- **States:** IDLE, BUSY, GAP, TWAIT.
- **Reset values:** all outputs 0, state IDLE, tWR counter 0, `last` = 1 (requester 0 wins the first tie).
- **IDLE arbitration:**
  - A requester is pending when its `iCall` ≠ 0.
  - If only one is pending, it wins.
  - If both are pending, the winner is the one that is not `last`.
  - On a win: latch the winner's address and data into `oIICAddr` / `oIICData`.
  - Set `oIICCall` to `2'b10` if the winner's bit 1 is set, else `2'b01`.
  - Record the winner in `owner` and the operation type in `wr`. Set `last` to the winner. Go to BUSY.
- **BUSY:**
  - Hold `oIICCall`, `oIICAddr` and `oIICData` stable.
  - Requester inputs are ignored, including a withdrawn or changed call; the operation always completes.
  - Engine NACK retries are internal to the engine; BUSY simply waits and has no timeout.
- **On `iIICDone` in BUSY:**
  - `oIICCall` is cleared by the same clock edge that samples the done pulse. The engine therefore sees its call high during the done cycle, which lets its sequencer return to idle.
  - Pulse `oDone[owner]` for one cycle.
  - For a read, load `oData[owner]` from `iIICData`.
  - Go to TWAIT (write) or GAP (read).
- **GAP:** one cycle so the requester can drop its call, then IDLE.
- **TWAIT:** load the counter with `TWR-1`, decrement to 0, then IDLE. No grant is made during TWAIT; requests stay pending.
- **Requester contract:** the requester must drop `iCall` within one cycle of its `oDone`, otherwise it is re-served as a new request.
- **Data retention:** `oData0` / `oData1` change only on their own read completion; writes never change them.
- **Mid-operation reset:** outputs return to reset values at once. The engine is reset by the same `RESET`.

## Timing
- Request seen in IDLE at edge n → `oIICCall` and the latched address/data valid from cycle n+1.
- `iIICDone` high in cycle m:
  - `oIICCall` = 0 from m+1.
  - `oDoneX` = 1 only in cycle m+1.
  - `oDataX` valid from m+1.
- Read turnaround: GAP in m+1, IDLE in m+2, earliest next `oIICCall` in m+3.
- Write turnaround: TWAIT occupies cycles m+1 … m+TWR, IDLE in m+TWR+1, earliest next call in m+TWR+2.
- Both `oDone` outputs are never high in the same cycle. `oIICCall` is never `2'b11`.
- A request arriving in the same cycle as the block enters IDLE is arbitrated in that cycle.

## Test plan
- **Read, single requester:** requester 0 read of addr `0x3C`; engine model returns `0xA5` with done 40 cycles after the call → `oIICCall` = `01` and `oIICAddr` = `0x3C` one cycle after the request; `oDone0` pulses once; `oData0` = `0xA5`; `oData1` stays 0.
- **Write, tWR hold:** requester 1 writes `0x5A` to `0x10` with `TWR` = 8 → `oIICCall` = `10` and `oIICData` = `0x5A`; `oDone1` pulses. A requester 0 read issued immediately waits and its call appears exactly 9 cycles after `oDone1`.
- **Tie and round-robin:** both requesters issue reads continuously from reset → grants alternate 0, 1, 0, 1. No `oDone` overlap.
- **Write priority and stability:** requester 0 sets `iCall0` = `11` → the engine sees `10`. Changing `iAddr0` during BUSY leaves `oIICAddr` unchanged.
- **Withdrawn call:** requester drops its call mid-BUSY → the operation still completes and `oDone` still pulses. The call drop is registered on the same edge that sees done.
- **Reset mid-operation:** assert `RESET` in BUSY → all outputs 0 immediately; after release, requester 0 wins the first tie.
